// File: rtl/reg_shift_param.sv
// Parametrised universal shift register: shift, rotate, parallel load and a counted
// multi-position shift with BUSY/DONE handshake, plus per-slice serial taps.
module reg_shift_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4,
  parameter int unsigned AMT_W = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENB,
  input  logic                   DIR,
  input  logic                   S_IN,
  input  logic [1:0]             MODO,
  input  logic [WIDTH-1:0]       D,
  input  logic                   START,
  input  logic [AMT_W-1:0]       AMT,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH/SLICE-1:0] S_OUT,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int unsigned NumSlices = WIDTH / SLICE;

  localparam logic [1:0] ModeShift  = 2'b00;
  localparam logic [1:0] ModeRotate = 2'b01;
  localparam logic [1:0] ModeLoad   = 2'b10;
  localparam logic [1:0] ModeCount  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             sin_q, sin_d;

  logic start_hit;
  assign start_hit = ENB && (MODO == ModeCount) && START;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FIN always retires so DONE is never stretched by ENB
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_hit) begin
          state_d = (AMT == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (ENB && (cnt_q == AMT_W'(1))) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
      sin_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      sin_q <= sin_d;
    end
  end

  // Datapath next-state
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    sin_d = sin_q;
    if (ENB) begin
      unique case (state_q)
        StIdle: begin
          unique case (MODO)
            ModeShift: begin
              q_d = DIR ? {S_IN, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], S_IN};
            end
            ModeRotate: begin
              q_d = DIR ? {q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            end
            ModeLoad: begin
              q_d = D;
            end
            ModeCount: begin
              // Direction and fill are captured here so the run ignores live inputs
              if (START && (AMT != '0)) begin
                cnt_d = AMT;
                dir_d = DIR;
                sin_d = S_IN;
              end
            end
            default: q_d = q_q;
          endcase
        end
        StRun: begin
          q_d   = dir_q ? {sin_q, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], sin_q};
          cnt_d = cnt_q - AMT_W'(1);
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // Outputs; taps follow the live DIR even while a counted shift runs
  always_comb begin
    Q    = q_q;
    BUSY = (state_q == StRun);
    DONE = (state_q == StFin);
    S_OUT = '0;
    for (int unsigned i = 0; i < NumSlices; i++) begin
      S_OUT[i] = DIR ? q_q[i*SLICE] : q_q[i*SLICE+SLICE-1];
    end
  end

endmodule

// File: tb/tb_reg_shift_param.sv
// Self-checking bench for reg_shift_param: directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_reg_shift_param;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int AW = 5;

  logic            CLK = 1'b0;
  logic            RST, ENB, DIR, S_IN, START;
  logic [1:0]      MODO;
  logic [W-1:0]    D;
  logic [AW-1:0]   AMT;
  logic [W-1:0]    Q;
  logic [W/S-1:0]  S_OUT;
  logic            BUSY, DONE;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m;  // model of Q between tests

  reg_shift_param #(.WIDTH(W), .SLICE(S), .AMT_W(AW)) dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D),
    .START(START), .AMT(AMT), .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_tap(input logic [31:0] q, input logic dir);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = dir ? q[4*i] : q[4*i+3];
    return r;
  endfunction

  // Result of n single-position shifts with constant fill
  function automatic logic [31:0] shiftn(input logic [31:0] q, input logic dir,
                                         input logic sin, input int n);
    logic [31:0] fill;
    if (n >= 32) return sin ? 32'hFFFF_FFFF : 32'h0;
    if (!dir) begin
      fill = sin ? ((32'h1 << n) - 32'h1) : 32'h0;
      return (q << n) | fill;
    end
    fill = sin ? ~(32'hFFFF_FFFF >> n) : 32'h0;
    return (q >> n) | fill;
  endfunction

  task automatic test_reset();
    RST = 1'b1; ENB = 1'b0; MODO = 2'b10; D = 32'hFFFF_FFFF; START = 1'b0;
    DIR = 1'b0; S_IN = 1'b0; AMT = '0;
    cyc();
    n_checks++;
    if (Q !== 32'h0) $display("FAIL reset_q got %h want %h", Q, 32'h0); else n_pass++;
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
    n_checks++;
    if (DONE !== 1'b0) $display("FAIL reset_done got %b want 0", DONE); else n_pass++;
    RST = 1'b0; ENB = 1'b1; MODO = 2'b11;
    m = 32'h0;
  endtask

  task automatic test_walk();
    logic [31:0] e;
    MODO = 2'b10; D = 32'h1; cyc();
    MODO = 2'b00; DIR = 1'b0; S_IN = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      e = (k < 32) ? (32'h1 << k) : 32'h0;
      n_checks++;
      if (Q !== e) $display("FAIL walk_q k=%0d got %h want %h", k, Q, e); else n_pass++;
      n_checks++;
      if (S_OUT !== exp_tap(e, 1'b0))
        $display("FAIL walk_tap k=%0d got %h want %h", k, S_OUT, exp_tap(e, 1'b0));
      else n_pass++;
      n_checks++;
      if (S_OUT[7] !== (e == 32'h8000_0000))
        $display("FAIL walk_tap7 k=%0d got %b want %b", k, S_OUT[7], e == 32'h8000_0000);
      else n_pass++;
      if (k < 33) cyc();
    end
    MODO = 2'b11;
    m = 32'h0;
  endtask

  task automatic test_rotate();
    MODO = 2'b10; D = 32'h8000_0001; cyc();
    MODO = 2'b01; DIR = 1'b0; S_IN = 1'b0; cyc();
    n_checks++;
    if (Q !== 32'h0000_0003) $display("FAIL rot_left got %h want %h", Q, 32'h3); else n_pass++;
    MODO = 2'b10; cyc();
    MODO = 2'b01; DIR = 1'b1; S_IN = 1'b0; cyc();
    n_checks++;
    if (Q !== 32'hC000_0000) $display("FAIL rot_right got %h want %h", Q, 32'hC000_0000);
    else n_pass++;
    n_checks++;
    if (S_OUT !== exp_tap(32'hC000_0000, 1'b1))
      $display("FAIL rot_tap got %h want %h", S_OUT, exp_tap(32'hC000_0000, 1'b1));
    else n_pass++;
    MODO = 2'b11; DIR = 1'b0;
    m = 32'hC000_0000;
  endtask

  // Counted shift with optional mid-run stall and an ignored START poke while busy
  task automatic run_counted(input logic [31:0] q0, input logic dir, input logic sin,
                             input int amt, input int stall_at, input int stall_len,
                             input int poke_t, input string name);
    int done_t;
    int en_edges;
    logic [31:0] e;
    MODO = 2'b10; D = q0; ENB = 1'b1; START = 1'b0; cyc();
    MODO = 2'b11; DIR = dir; S_IN = sin; AMT = amt[AW-1:0]; START = 1'b1; cyc();
    START = 1'b0;
    done_t = (amt == 0) ? 0 : amt + stall_len;
    en_edges = 0;
    for (int t = 0; t <= done_t + 3; t++) begin
      e = shiftn(q0, dir, sin, (en_edges < amt) ? en_edges : amt);
      n_checks++;
      if (Q !== e) $display("FAIL %s_q t=%0d got %h want %h", name, t, Q, e); else n_pass++;
      n_checks++;
      if (BUSY !== (amt != 0 && t < done_t))
        $display("FAIL %s_busy t=%0d got %b want %b", name, t, BUSY, amt != 0 && t < done_t);
      else n_pass++;
      n_checks++;
      if (DONE !== (t == done_t))
        $display("FAIL %s_done t=%0d got %b want %b", name, t, DONE, t == done_t);
      else n_pass++;
      n_checks++;
      if (S_OUT !== exp_tap(e, DIR))
        $display("FAIL %s_tap t=%0d got %h want %h", name, t, S_OUT, exp_tap(e, DIR));
      else n_pass++;
      ENB = !((t + 1) > stall_at && (t + 1) <= stall_at + stall_len) && (t != done_t);
      if (t == poke_t) begin
        START = 1'b1; AMT = 5'd3; DIR = ~dir; S_IN = ~sin; D = $urandom;
      end else begin
        START = 1'b0; DIR = 1'($urandom); S_IN = 1'($urandom);
      end
      cyc();
      if (ENB) en_edges++;
    end
    ENB = 1'b1; START = 1'b0;
    m = shiftn(q0, dir, sin, amt);
  endtask

  task automatic test_counted();
    run_counted(32'h0000_00FF, 1'b0, 1'b0, 8, 0, 0, -1, "counted");
  endtask

  task automatic test_stall();
    run_counted(32'h0000_00FF, 1'b0, 1'b0, 8, 3, 3, 2, "stall");
  endtask

  task automatic test_amt0();
    run_counted(32'h1234_5678, 1'b1, 1'b1, 0, 0, 0, -1, "amt0");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    MODO = 2'b10; D = 32'hA5A5_A5A5; cyc();
    MODO = 2'b11; DIR = 1'b0; S_IN = 1'b1; AMT = 5'd20; START = 1'b1; cyc();
    START = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if (Q !== shiftn(32'hA5A5_A5A5, 1'b0, 1'b1, 4))
      $display("FAIL rstmid_pre got %h want %h", Q, shiftn(32'hA5A5_A5A5, 1'b0, 1'b1, 4));
    else n_pass++;
    RST = 1'b1; cyc();
    n_checks++;
    if (Q !== 32'h0) $display("FAIL rstmid_q got %h want 0", Q); else n_pass++;
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL rstmid_busy got %b want 0", BUSY); else n_pass++;
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (DONE !== 1'b0 || BUSY !== 1'b0) done_seen++;
      cyc();
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL rstmid_after got %0d active cycles want 0", done_seen);
    else n_pass++;
    m = 32'h0;
  endtask

  task automatic test_random();
    int op, amt, sa, sl, pk;
    logic en, dr, si;
    logic [31:0] dv;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      dr = 1'($urandom); si = 1'($urandom); dv = $urandom;
      if (op == 3) begin
        amt = $urandom_range(0, 31);
        sa = 0; sl = 0; pk = -1;
        if (amt >= 2) begin
          sa = $urandom_range(1, amt - 1);
          sl = $urandom_range(0, 3);
          pk = $urandom_range(0, amt - 1);
        end
        run_counted(dv, dr, si, amt, sa, sl, pk, "rand_cnt");
      end else begin
        en = ($urandom_range(0, 3) != 0);
        MODO = 2'(op); DIR = dr; S_IN = si; D = dv; ENB = en; cyc();
        if (en) begin
          case (op)
            0: m = dr ? ((m >> 1) | (32'(si) << 31)) : ((m << 1) | 32'(si));
            1: m = dr ? ((m >> 1) | (m << 31)) : ((m << 1) | (m >> 31));
            default: m = dv;
          endcase
        end
        n_checks++;
        if (Q !== m) $display("FAIL rand_op%0d i=%0d got %h want %h", op, i, Q, m); else n_pass++;
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0)
          $display("FAIL rand_idle i=%0d got busy=%b done=%b want 0 0", i, BUSY, DONE);
        else n_pass++;
        ENB = 1'b1; MODO = 2'b11;
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_rotate();
    test_counted();
    test_stall();
    test_amt0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_shift_param.md
Name: reg_shift_param

Overview:
- Parametrised universal shift register, successor to the fixed 32-bit, 8×4-bit-slice shift register.
- Generalised in width and slice count.
- Adds a synchronous active-high reset, a rotate mode, and a counted multi-position shift mode with BUSY/DONE handshake.
- Sits in the datapath wherever the team needs load/shift/rotate of a word, with per-slice serial taps.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of SLICE and ≥ 2×SLICE.
- SLICE, 4, bits per slice; one S_OUT tap per slice.
- AMT_W, 5, width of AMT; must satisfy 2^AMT_W ≥ WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- ENB  input  1  clock enable; when low, all state holds.
- DIR  input  1  0 = shift left (toward MSB), 1 = shift right.
- S_IN  input  1  serial fill bit for shift modes.
- MODO  input  2  mode: 00 shift, 01 rotate, 10 parallel load, 11 counted shift.
- D  input  WIDTH  parallel load data.
- START  input  1  launches counted shift (MODO=11 only).
- AMT  input  AMT_W  number of positions for counted shift.
- Q  output  WIDTH  register contents.
- S_OUT  output  WIDTH/SLICE  per-slice serial taps.
- BUSY  output  1  counted shift in progress.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RST=1 at an edge, regardless of ENB or state):
  - Q=0, BUSY=0, DONE=0, counter=0, FSM → IDLE.
  - Reset mid-operation aborts the run; no DONE pulse is produced.
- ENB=0: Q, counter and FSM hold. DONE still clears after its single cycle, so the pulse is never stretched.
- FSM states: IDLE, RUN, FIN.
  - BUSY=1 only in RUN.
  - DONE=1 only in FIN.
  - FIN → IDLE unconditionally on the next edge.
- IDLE with ENB=1:
  - MODO=00: left Q ← {Q[WIDTH-2:0], S_IN}; right Q ← {S_IN, Q[WIDTH-1:1]}.
  - MODO=01: left Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}; right Q ← {Q[0], Q[WIDTH-1:1]}. S_IN is ignored.
  - MODO=10: Q ← D.
  - MODO=11, START=0: hold.
  - MODO=11, START=1, AMT=0: go to FIN; Q unchanged.
  - MODO=11, START=1, AMT≠0: latch DIR and S_IN, counter ← AMT, go to RUN. Q is not shifted on the START edge.
- RUN with ENB=1:
  - Each edge: one shift in the latched direction, filling with the latched S_IN; counter decrements.
  - When counter==1 at the edge, go to FIN.
- RUN with ENB=0: stall; nothing changes.
- RUN ignores MODO, DIR, S_IN, D, START and AMT.
- Latency: START accepted at edge k → shifts at edges k+1..k+AMT (ENB high) → DONE=1 during the cycle after edge k+AMT.
- AMT ≥ WIDTH is legal; the result is Q filled entirely with the latched S_IN.
- S_OUT (combinational from Q), slice i covers Q[i*SLICE+SLICE-1 : i*SLICE]:
  - DIR=0: S_OUT[i] = Q[i*SLICE+SLICE-1].
  - DIR=1: S_OUT[i] = Q[i*SLICE].
  - Live DIR selects the tap, also during RUN.
- Arithmetic: counter is AMT_W bits, no wrap; decrement only in RUN.

Test Plan:
- Left walk-out: RST; MODO=10, D=0x00000001, 1 clk; MODO=00, DIR=0, S_IN=0, 33 clks.
  - Q=1<<k after k shifts; Q=0 after 32.
  - S_OUT[7]=1 only while Q=0x80000000.
- Rotate: load 0x80000001.
  - MODO=01, DIR=0, 1 clk → Q=0x00000003.
  - Reload, DIR=1, 1 clk → Q=0xC0000000.
- Counted shift: load 0x000000FF; MODO=11, DIR=0, S_IN=0, START=1 (1 cycle), AMT=8.
  - BUSY high 8 cycles; Q=0x0000FF00.
  - DONE=1 for exactly 1 cycle, 9 cycles after the START edge; then IDLE.
- Stall and ignore: as the counted-shift case, but drop ENB for 3 cycles mid-run and pulse START with AMT=3 while BUSY.
  - Q frozen during stall; final Q=0x0000FF00.
  - DONE delayed by 3 cycles; second START ignored.
- AMT=0: START with AMT=0 → DONE one cycle later; BUSY never high; Q unchanged.
- Reset mid-run: AMT=20, assert RST at 5th RUN cycle.
  - Next cycle Q=0, BUSY=0; DONE stays 0 for the following 30 cycles.
